// File: rtl/pipe_skid_stage.sv
// Elastic pipeline stage: registered valid/ready handshake with a
// one-entry skid buffer so in_ready never depends on out_ready.
//
// Ports:
//   clk       - clock, all state updates on rising edge
//   reset     - asynchronous reset, active-low
//   flush     - synchronous clear of all held words
//   in_valid  - upstream presents a word on in
//   in_ready  - stage can accept a word this cycle (registered)
//   in        - upstream data, N bits
//   out_valid - out holds a valid word
//   out_ready - downstream accepts out this cycle
//   out       - downstream data, N bits
module pipe_skid_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] in,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out
);

    // Bit 0 is main_valid, bit 1 is skid_valid; both outputs
    // therefore come straight from state flops.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        BUSY  = 2'b01,
        FULL  = 2'b11
    } state_t;

    state_t         state_q;
    state_t         state_d;
    logic [N-1:0]   main_q;
    logic [N-1:0]   main_d;
    logic [N-1:0]   skid_q;
    logic [N-1:0]   skid_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= EMPTY;
            main_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        unique case (state_q)
            EMPTY: begin
                if (in_valid) begin
                    main_d  = in;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (in_valid && out_ready) begin
                    main_d = in;
                end else if (in_valid) begin
                    // Downstream stalled: park the new word.
                    skid_d  = in;
                    state_d = FULL;
                end else if (out_ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_ready) begin
                    main_d  = skid_q;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush wins; data registers may keep stale contents.
        if (flush) begin
            state_d = EMPTY;
        end
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign out       = main_q;

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Elastic pipeline stage register with a valid/ready handshake and a one-entry skid buffer.
- Sits between two pipeline stages as the receiving end of the stage-to-stage interface. It gives upstream a registered backpressure signal (in_ready) in place of a plain write-enable flop.
- Sustains one transfer per cycle with 1-cycle latency.
- Absorbs one extra word when downstream stalls, so in_ready never depends combinationally on out_ready.

Parameters:
N, 32, data width in bits.

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous reset, active-low (0 = reset)
flush  input  1  synchronous clear of all held words (pipeline flush)
in_valid  input  1  upstream presents a word on in
in_ready  output  1  stage can accept a word this cycle (registered)
in  input  N  upstream data
out_valid  output  1  out holds a valid word
out_ready  input  1  downstream accepts out this cycle
out  output  N  downstream data

Behaviour:
- Handshake definitions:
  - Accept occurs when in_valid & in_ready are both 1 at a rising edge.
  - Transfer occurs when out_valid & out_ready are both 1 at a rising edge.
- Storage: main register (drives out, out_valid) and skid register (skid_data, skid_valid).
- Derived signals:
  - in_ready = !skid_valid, driven directly from a flop with no combinational path from out_ready.
  - out_valid = main_valid.
- Reset (reset=0, asynchronous):
  - main_valid=0, skid_valid=0, out=0, skid_data=0.
  - Hence out_valid=0 and in_ready=1 during reset and immediately after release.
- States:
  - EMPTY: main_valid=0, skid_valid=0.
  - BUSY: main_valid=1, skid_valid=0.
  - FULL: main_valid=1, skid_valid=1.
  - main_valid=0 with skid_valid=1 is illegal and never reached.
- Transitions (flush=0):
  - EMPTY:
    - in_valid: main<=in, go to BUSY.
    - else stay.
  - BUSY:
    - in_valid & out_ready: main<=in, stay BUSY (full throughput).
    - in_valid & !out_ready: skid<=in, go to FULL. in_ready drops the next cycle.
    - !in_valid & out_ready: go to EMPTY.
    - neither: hold.
  - FULL (in_ready=0, in ignored):
    - out_ready: main<=skid, go to BUSY. in_ready returns the next cycle.
    - else hold.
- Flush: highest priority over all transitions.
  - Next state is EMPTY. Any word accepted or transferred in the same cycle is discarded.
  - Data registers may keep stale values; only the valid bits clear.
- Latency: a word accepted at edge k appears on out with out_valid=1 after edge k (1 cycle).
- Ordering: strict FIFO. A skid word always follows the main word; no loss and no duplication.
- Stability: while out_valid=1 & out_ready=0, out and out_valid are held constant (no glitch, no replacement).
- Reset mid-operation: asserting reset in any state clears both entries immediately, without waiting for a clock edge. Held words are lost.
- out_ready with out_valid=0 has no effect.
- in changes while in_ready=0 have no effect.

Test Plan:
- Reset/idle (N=4): hold reset=0 for 2 cycles, then release -> out_valid=0, out=0, in_ready=1. Also assert reset=0 mid-cycle while FULL -> valids clear before the next edge.
- Streaming: out_ready=1, in_valid=1, in=1,2,3,4,5,6 on successive edges -> out=1..6 one cycle later each, out_valid continuously 1, in_ready continuously 1.
- Single stall:
  - Stream 1,2,3. Set out_ready=0 for the cycle when out=1 -> 2 goes to skid, in_ready=0 the next cycle, 3 is held by upstream.
  - Set out_ready=1 -> out sequence 1,2,3 with no gap after the stall, no loss, no duplicate.
- Long stall: out_ready=0 for 5 cycles while FULL -> out stays 1, in_ready stays 0, in changes ignored. Release -> 1 then 2 delivered.
- Flush:
  - Flush while FULL (words 7,8) -> next cycle out_valid=0, in_ready=1.
  - Flush together with in_valid=1, in=9 -> 9 is dropped and out_valid=0.
- Drain: in_valid=0 and out_ready=1 from BUSY -> EMPTY after one edge, out_valid=0.
